// File: rtl/up_down_dir_decoder.sv
// Direction recovery monitor for an up/down count stream.
// Flags wrap-around, reversals, illegal jumps, run length and stall.
module up_down_dir_decoder #(
    parameter int WIDTH    = 3,
    parameter int RUN_W    = 4,
    parameter int HOLD_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] count_in,
    output logic             mode_out,
    output logic             dir_valid,
    output logic             wrap,
    output logic             reversal,
    output logic             step_err,
    output logic             stall,
    output logic [RUN_W-1:0] step_cnt
);

    typedef enum logic [2:0] {ACQ, SYNC, UP, DOWN, ERR} state_t;

    localparam logic [WIDTH-1:0] MAXV     = '1;
    localparam logic [RUN_W-1:0] RUN_MAX  = '1;
    localparam logic [RUN_W-1:0] HOLD_LIM = RUN_W'(HOLD_MAX);

    state_t           state;
    logic [WIDTH-1:0] prev;
    logic [RUN_W-1:0] hold_cnt;

    logic [WIDTH-1:0] delta;
    logic             is_up;
    logic             is_dn;
    logic             is_hold;
    logic             wrap_hit;
    logic             same_dir;
    logic             opp_dir;
    logic [RUN_W-1:0] hold_inc;
    logic [RUN_W-1:0] run_inc;

    always_comb begin
        delta    = count_in - prev;
        is_up    = (delta == WIDTH'(1));
        is_dn    = (delta == MAXV);
        is_hold  = (delta == '0);
        // max->0 going up, or 0->max going down
        wrap_hit = (is_up && count_in == '0) || (is_dn && prev == '0);
        same_dir = (is_up && state == UP) || (is_dn && state == DOWN);
        opp_dir  = (is_up && state == DOWN) || (is_dn && state == UP);
        hold_inc = (hold_cnt == RUN_MAX) ? hold_cnt : hold_cnt + 1'b1;
        run_inc  = (step_cnt == RUN_MAX) ? step_cnt : step_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACQ;
            prev      <= '0;
            hold_cnt  <= '0;
            mode_out  <= 1'b0;
            dir_valid <= 1'b0;
            wrap      <= 1'b0;
            reversal  <= 1'b0;
            step_err  <= 1'b0;
            stall     <= 1'b0;
            step_cnt  <= '0;
        end else if (valid_in) begin
            prev     <= count_in;
            wrap     <= 1'b0;
            reversal <= 1'b0;
            step_err <= 1'b0;
            unique case (state)
                // no reference yet: this sample only seeds prev
                ACQ, ERR: begin
                    state     <= SYNC;
                    dir_valid <= 1'b0;
                end
                default: begin
                    unique case (1'b1)
                        is_up, is_dn: begin
                            state     <= is_up ? UP : DOWN;
                            mode_out  <= is_dn;
                            dir_valid <= 1'b1;
                            wrap      <= wrap_hit;
                            reversal  <= opp_dir;
                            step_cnt  <= same_dir ? run_inc : RUN_W'(1);
                            hold_cnt  <= '0;
                            stall     <= 1'b0;
                        end
                        is_hold: begin
                            hold_cnt <= hold_inc;
                            stall    <= (hold_inc >= HOLD_LIM);
                        end
                        default: begin
                            state     <= ERR;
                            dir_valid <= 1'b0;
                            step_err  <= 1'b1;
                            step_cnt  <= '0;
                            hold_cnt  <= '0;
                            stall     <= 1'b0;
                        end
                    endcase
                end
            endcase
        end else begin
            wrap     <= 1'b0;
            reversal <= 1'b0;
            step_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_up_down_dir_decoder.sv
// Bench for up_down_dir_decoder: per-cycle model compare plus
// directed scenarios with hand-computed expectations.
module tb_up_down_dir_decoder;

    localparam int WIDTH    = 3;
    localparam int RUN_W    = 4;
    localparam int HOLD_MAX = 4;
    localparam int MODV     = 1 << WIDTH;
    localparam int RUNSAT   = (1 << RUN_W) - 1;

    logic             clk;
    logic             rst;
    logic             valid_in;
    logic [WIDTH-1:0] count_in;
    logic             mode_out;
    logic             dir_valid;
    logic             wrap;
    logic             reversal;
    logic             step_err;
    logic             stall;
    logic [RUN_W-1:0] step_cnt;

    up_down_dir_decoder #(
        .WIDTH(WIDTH),
        .RUN_W(RUN_W),
        .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .count_in(count_in),
        .mode_out(mode_out),
        .dir_valid(dir_valid),
        .wrap(wrap),
        .reversal(reversal),
        .step_err(step_err),
        .stall(stall),
        .step_cnt(step_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: reference presence, signed direction, run and hold lengths
    bit m_ref;
    int m_prev;
    int m_dir;
    int m_run;
    int m_hold;
    bit e_mode, e_dv, e_wrap, e_rev, e_err, e_stall;

    always @(posedge clk) begin
        int d, st;
        if (rst) begin
            m_ref = 0; m_prev = 0; m_dir = 0; m_run = 0; m_hold = 0;
            e_mode = 0; e_wrap = 0; e_rev = 0; e_err = 0;
        end else begin
            e_wrap = 0; e_rev = 0; e_err = 0;
            if (valid_in) begin
                if (!m_ref) begin
                    m_ref = 1;
                    m_dir = 0;
                end else begin
                    d  = (int'(count_in) - m_prev + MODV) % MODV;
                    st = (d == 1) ? 1 : (d == MODV - 1) ? -1 : (d == 0) ? 0 : 99;
                    if (st == 99) begin
                        e_err = 1;
                        m_ref = 0; m_dir = 0; m_run = 0; m_hold = 0;
                    end else if (st == 0) begin
                        m_hold = (m_hold < RUNSAT) ? m_hold + 1 : RUNSAT;
                    end else begin
                        m_hold = 0;
                        e_rev  = (m_dir == -st);
                        e_wrap = (st == 1 && count_in == 0) ||
                                 (st == -1 && int'(count_in) == MODV - 1);
                        m_run  = (m_dir == st) ? ((m_run < RUNSAT) ? m_run + 1 : RUNSAT) : 1;
                        m_dir  = st;
                        e_mode = (st < 0);
                    end
                end
                m_prev = int'(count_in);
            end
        end
        e_dv    = (m_dir != 0);
        e_stall = (m_hold >= HOLD_MAX);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_mode", mode_out, e_mode);
            chk("cyc_dir_valid", dir_valid, e_dv);
            chk("cyc_wrap", wrap, e_wrap);
            chk("cyc_reversal", reversal, e_rev);
            chk("cyc_step_err", step_err, e_err);
            chk("cyc_stall", stall, e_stall);
            chk("cyc_step_cnt", step_cnt, m_run);
        end
    end

    task automatic drive(input logic r, input logic v, input int c);
        rst      = r;
        valid_in = v;
        count_in = WIDTH'(c);
        @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input int vals[$]);
        foreach (vals[i]) drive(0, 1, vals[i]);
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; count_in = '0;
        drive(1, 0, 0);
        chk_en = 1;
        chk("rst_dir_valid", dir_valid, 0);
        chk("rst_step_cnt", step_cnt, 0);
        chk("rst_mode", mode_out, 0);

        // 1: up run with wrap
        drive(0, 1, 0);
        chk("t1_first_dv", dir_valid, 0);
        for (int k = 1; k <= 9; k++) begin
            drive(0, 1, k % MODV);
            chk("t1_cnt", step_cnt, k);
            chk("t1_wrap", wrap, (k == 8) ? 1 : 0);
        end
        chk("t1_model_run", m_run, 9);
        chk("t1_dv", dir_valid, 1);

        // 2: reversal
        drive(1, 0, 0);
        run_seq('{2, 3, 4, 3});
        chk("t2_rev", reversal, 1);
        chk("t2_mode", mode_out, 1);
        chk("t2_cnt1", step_cnt, 1);
        drive(0, 1, 2);
        chk("t2_cnt2", step_cnt, 2);
        chk("t2_norev", reversal, 0);

        // 3: illegal jump and recovery
        drive(1, 0, 0);
        run_seq('{5, 6, 1});
        chk("t3_err", step_err, 1);
        chk("t3_dv", dir_valid, 0);
        chk("t3_cnt", step_cnt, 0);
        drive(0, 1, 2);
        chk("t3_sync_noerr", step_err, 0);
        chk("t3_sync_dv", dir_valid, 0);
        drive(0, 1, 3);
        chk("t3_up_dv", dir_valid, 1);
        chk("t3_up_cnt", step_cnt, 1);

        // 4: stall
        drive(1, 0, 0);
        run_seq('{3, 4, 4, 4, 4});
        chk("t4_nostall3", stall, 0);
        drive(0, 1, 4);
        chk("t4_stall", stall, 1);
        chk("t4_cnt_hold", step_cnt, 1);
        drive(0, 1, 5);
        chk("t4_unstall", stall, 0);
        chk("t4_cnt", step_cnt, 2);

        // 5: saturation with gaps
        drive(1, 0, 0);
        drive(0, 1, 0);
        for (int k = 1; k <= 16; k++) begin
            drive(0, 0, $urandom_range(0, MODV - 1));
            drive(0, 1, k % MODV);
        end
        chk("t5_sat", step_cnt, RUNSAT);
        chk("t5_model_sat", m_run, RUNSAT);
        drive(0, 0, 3);
        chk("t5_idle_cnt", step_cnt, RUNSAT);

        // 6: reset mid down run
        drive(1, 0, 0);
        run_seq('{7, 6, 5});
        chk("t6_pre_cnt", step_cnt, 2);
        drive(1, 1, 4);
        chk("t6_rst_mode", mode_out, 0);
        chk("t6_rst_dv", dir_valid, 0);
        chk("t6_rst_cnt", step_cnt, 0);
        drive(0, 1, 4);
        chk("t6_acq_err", step_err, 0);
        drive(0, 1, 3);
        chk("t6_norev", reversal, 0);
        chk("t6_mode", mode_out, 1);

        // down wrap straight out of sync
        drive(1, 0, 0);
        run_seq('{0, 7});
        chk("dwrap_wrap", wrap, 1);
        chk("dwrap_mode", mode_out, 1);
        drive(0, 0, 0);
        chk("dwrap_pulse_gone", wrap, 0);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
